// File: rtl/ppl_pkg.sv
// Shared definitions for the ray-march retire stage: palette, face codes,
// controller states and the RGB565 face-shading function.
package ppl_pkg;

  localparam int FIFO_WIDTH = 36;

  localparam logic [15:0] SKY        = 16'h867D;
  localparam logic [15:0] COL_GRASS  = 16'h07E0;
  localparam logic [15:0] COL_DIRT   = 16'h8A22;
  localparam logic [15:0] COL_STONE  = 16'h8410;
  localparam logic [15:0] COL_WOOD   = 16'hA285;
  localparam logic [15:0] COL_LEAVES = 16'h0400;
  localparam logic [15:0] COL_OTHER  = 16'hF81F;

  localparam logic [1:0] FACE_Y = 2'd0;
  localparam logic [1:0] FACE_X = 2'd1;
  localparam logic [1:0] FACE_Z = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [15:0] base_colour(input logic [3:0] id);
    case (id)
      4'd1:    return COL_GRASS;
      4'd2:    return COL_DIRT;
      4'd3:    return COL_STONE;
      4'd4:    return COL_WOOD;
      4'd5:    return COL_LEAVES;
      default: return COL_OTHER;
    endcase
  endfunction

  // Shading works on each 5/6/5 field separately so no carry crosses fields;
  // the reserved face code falls through as unshaded.
  function automatic logic [15:0] shade(input logic [15:0] c, input logic [1:0] face);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = c[15:11];
    g = c[10:5];
    b = c[4:0];
    case (face)
      FACE_X: begin
        r = r - (r >> 2);
        g = g - (g >> 2);
        b = b - (b >> 2);
      end
      FACE_Z: begin
        r = r >> 1;
        g = g >> 1;
        b = b >> 1;
      end
      default: ;
    endcase
    return {r, g, b};
  endfunction

  function automatic logic [15:0] pixel_colour(input logic hit, input logic [3:0] id,
                                               input logic [1:0] face);
    return hit ? shade(base_colour(id), face) : SKY;
  endfunction

endpackage

// File: rtl/ppl_exit_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags and level.
module ppl_exit_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign drop    = push & full;
  assign head    = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (do_push && !do_pop)
      level_next = level + (AW+1)'(1);
    else if (!do_push && do_pop)
      level_next = level - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == DEPTH_L);
      empty <= (level_next == '0);
    end
  end

  // Storage is not reset; the consumer only looks at it while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ppl_exit.sv
// Retire stage of the ray-march pipeline: shades terminated rays, queues them
// for the framebuffer and tracks frame progress through issue/retire counts.
module ppl_exit
  import ppl_pkg::*;
#(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int MAX_STEPS  = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        in_valid,
  input  logic        hit,
  input  logic [3:0]  block_id,
  input  logic [1:0]  hit_face,
  input  logic [3:0]  block_cnt_out,
  input  logic [19:0] pixel_addr_out,
  output logic        next_en,
  output logic        scanner_stop,
  output logic        fb_wr_valid,
  input  logic        fb_wr_ready,
  output logic [19:0] fb_wr_addr,
  output logic [15:0] fb_wr_data,
  output logic        frame_done,
  output logic        overflow
);

  localparam int CNT_W = 21;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(H_DISP * V_DISP);
  localparam logic [CNT_W-1:0] TOTAL_M1 = CNT_W'(H_DISP * V_DISP - 1);
  localparam logic [3:0]       STEP_LIM = 4'(MAX_STEPS);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        retire_cnt;
  logic                    term;
  logic                    active;
  logic                    issue;
  logic                    last_issue;
  logic                    retire;
  logic                    retire_ok;
  logic                    pop;
  logic                    drained;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_drop;
  logic [LW-1:0]           fifo_level;
  logic [FIFO_WIDTH-1:0]   head;

  assign term       = in_valid & (hit | (block_cnt_out >= STEP_LIM));
  assign next_en    = ~fifo_full & (~in_valid | term);
  assign active     = (state == S_RUN) | (state == S_DRAIN);
  assign issue      = next_en & ~scanner_stop & (state == S_RUN);
  assign last_issue = issue & (issue_cnt == TOTAL_M1);
  assign retire     = next_en & term & active;
  assign retire_ok  = retire & (retire_cnt != TOTAL);
  assign pop        = fb_wr_valid & fb_wr_ready;

  // Look ahead through a pop of the final entry so frame_done lands right
  // after the last framebuffer write.
  assign drained = (retire_cnt == TOTAL) &
                   ((fifo_level == '0) | ((fifo_level == LW'(1)) & pop));

  assign fb_wr_valid = ~fifo_empty;
  assign fb_wr_addr  = fifo_empty ? 20'd0 : head[35:16];
  assign fb_wr_data  = fifo_empty ? 16'd0 : head[15:0];
  assign frame_done  = (state == S_DONE);

  ppl_exit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (retire_ok),
    .push_data ({pixel_addr_out, pixel_colour(hit, block_id, hit_face)}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (frame_start) state_next = S_RUN;
      S_RUN:   if (last_issue)  state_next = S_DRAIN;
      S_DRAIN: if (drained)     state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      issue_cnt    <= '0;
      retire_cnt   <= '0;
      scanner_stop <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && frame_start) begin
        issue_cnt    <= '0;
        retire_cnt   <= '0;
        scanner_stop <= 1'b0;
      end else begin
        if (issue)      issue_cnt    <= issue_cnt + CNT_W'(1);
        if (last_issue) scanner_stop <= 1'b1;
        if (retire_ok)  retire_cnt   <= retire_cnt + CNT_W'(1);
      end
      if ((retire & (retire_cnt == TOTAL)) | fifo_drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppl_exit.sv
// Directed bench for ppl_exit: a full-size instance for shading/back-pressure
// and a 4x2 instance for whole-frame sequencing and mid-frame reset.
module tb_ppl_exit;

  logic        clk = 1'b0;
  logic        rst;
  logic        big_start;
  logic        small_start;
  logic        in_valid;
  logic        hit;
  logic [3:0]  block_id;
  logic [1:0]  hit_face;
  logic [3:0]  block_cnt_out;
  logic [19:0] pixel_addr_out;
  logic        ready;

  logic        b_next_en, b_stop, b_valid, b_done, b_ovf;
  logic [19:0] b_addr;
  logic [15:0] b_data;
  logic        s_next_en, s_stop, s_valid, s_done, s_ovf;
  logic [19:0] s_addr;
  logic [15:0] s_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ppl_exit dut_big (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (big_start),
    .in_valid       (in_valid),
    .hit            (hit),
    .block_id       (block_id),
    .hit_face       (hit_face),
    .block_cnt_out  (block_cnt_out),
    .pixel_addr_out (pixel_addr_out),
    .next_en        (b_next_en),
    .scanner_stop   (b_stop),
    .fb_wr_valid    (b_valid),
    .fb_wr_ready    (ready),
    .fb_wr_addr     (b_addr),
    .fb_wr_data     (b_data),
    .frame_done     (b_done),
    .overflow       (b_ovf)
  );

  ppl_exit #(.H_DISP(4), .V_DISP(2)) dut_small (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (small_start),
    .in_valid       (in_valid),
    .hit            (hit),
    .block_id       (block_id),
    .hit_face       (hit_face),
    .block_cnt_out  (block_cnt_out),
    .pixel_addr_out (pixel_addr_out),
    .next_en        (s_next_en),
    .scanner_stop   (s_stop),
    .fb_wr_valid    (s_valid),
    .fb_wr_ready    (ready),
    .fb_wr_addr     (s_addr),
    .fb_wr_data     (s_data),
    .frame_done     (s_done),
    .overflow       (s_ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ray(input logic v, input logic h, input logic [3:0] id,
                           input logic [1:0] face, input logic [3:0] cnt,
                           input logic [19:0] addr);
    in_valid       = v;
    hit            = h;
    block_id       = id;
    hit_face       = face;
    block_cnt_out  = cnt;
    pixel_addr_out = addr;
  endtask

  task automatic do_reset;
    big_start   = 1'b0;
    small_start = 1'b0;
    ready       = 1'b0;
    drive_ray(1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 20'd0);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_big_start;
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
  endtask

  task automatic test_reset;
    big_start   = 1'b0;
    small_start = 1'b0;
    ready       = 1'b0;
    drive_ray(1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 20'd0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++; if (b_next_en !== 1'b1) begin failures++; $display("[TB] FAIL reset_next_en got=%b exp=1", b_next_en); end
    checks++; if (b_stop !== 1'b1) begin failures++; $display("[TB] FAIL reset_stop got=%b exp=1", b_stop); end
    checks++; if (b_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", b_valid); end
    checks++; if (b_addr !== 20'd0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0", b_addr); end
    checks++; if (b_data !== 16'd0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", b_data); end
    checks++; if (b_done !== 1'b0 || b_ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_done_ovf got=%b%b exp=00", b_done, b_ovf); end
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (b_stop !== 1'b1 || b_next_en !== 1'b1 || b_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_hold cyc=%0d got stop/next/valid=%b%b%b exp=110", i, b_stop, b_next_en, b_valid);
      end
    end
    tick();
  endtask

  task automatic test_shade;
    logic [3:0]  ids   [4];
    logic [1:0]  faces [4];
    logic [15:0] cols  [4];
    ids[0] = 4'd3; faces[0] = 2'd0; cols[0] = 16'h8410;
    ids[1] = 4'd4; faces[1] = 2'd1; cols[1] = 16'h79E4;
    ids[2] = 4'd9; faces[2] = 2'd2; cols[2] = 16'h780F;
    ids[3] = 4'd2; faces[3] = 2'd3; cols[3] = 16'h8A22;
    do_reset();
    pulse_big_start();
    drive_ray(1'b1, 1'b1, 4'd1, 2'd2, 4'd0, 20'd5);
    @(negedge clk);
    checks++; if (b_next_en !== 1'b1) begin failures++; $display("[TB] FAIL hit_next_en got=%b exp=1", b_next_en); end
    tick();
    drive_ray(1'b1, 1'b1, 4'd1, 2'd1, 4'd0, 20'd6);
    ready = 1'b1;
    @(negedge clk);
    checks++; if (b_valid !== 1'b1 || b_addr !== 20'd5 || b_data !== 16'h03E0) begin
      failures++; $display("[TB] FAIL grass_z got v=%b a=%0d d=%h exp v=1 a=5 d=03e0", b_valid, b_addr, b_data); end
    tick();
    drive_ray(1'b1, 1'b0, 4'd0, 2'd0, 4'd15, 20'd100);
    @(negedge clk);
    checks++; if (b_addr !== 20'd6 || b_data !== 16'h0600) begin
      failures++; $display("[TB] FAIL grass_x got a=%0d d=%h exp a=6 d=0600", b_addr, b_data); end
    tick();
    drive_ray(1'b1, 1'b0, 4'd0, 2'd0, 4'd14, 20'd101);
    @(negedge clk);
    checks++; if (b_addr !== 20'd100 || b_data !== 16'h867D) begin
      failures++; $display("[TB] FAIL sky got a=%0d d=%h exp a=100 d=867d", b_addr, b_data); end
    checks++; if (b_next_en !== 1'b0) begin failures++; $display("[TB] FAIL marching_next_en got=%b exp=0", b_next_en); end
    tick();
    drive_ray(1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 20'd0);
    @(negedge clk);
    checks++; if (b_valid !== 1'b0) begin failures++; $display("[TB] FAIL no_push_marching got v=%b exp=0", b_valid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_ray(1'b1, 1'b1, ids[i], faces[i], 4'd0, 20'(300 + i));
      tick();
      drive_ray(1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 20'd0);
      @(negedge clk);
      checks++;
      if (b_valid !== 1'b1 || b_addr !== 20'(300 + i) || b_data !== cols[i]) begin
        failures++;
        $display("[TB] FAIL palette_%0d got v=%b a=%0d d=%h exp v=1 a=%0d d=%h", i, b_valid, b_addr, b_data, 300 + i, cols[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    pulse_big_start();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_ray(1'b1, 1'b1, 4'd5, 2'd0, 4'd0, 20'(200 + i));
      @(negedge clk);
      checks++; if (b_next_en !== 1'b1) begin failures++; $display("[TB] FAIL fill_next_en_%0d got=%b exp=1", i, b_next_en); end
      tick();
    end
    drive_ray(1'b1, 1'b1, 4'd5, 2'd0, 4'd0, 20'd250);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (b_next_en !== 1'b0 || b_valid !== 1'b1 || b_addr !== 20'd200 || b_data !== 16'h0400 || b_ovf !== 1'b0) begin
        failures++;
        $display("[TB] FAIL full_hold_%0d got n=%b v=%b a=%0d d=%h o=%b exp n=0 v=1 a=200 d=0400 o=0", i, b_next_en, b_valid, b_addr, b_data, b_ovf);
      end
      tick();
    end
    drive_ray(1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 20'd0);
    ready = 1'b1;
    @(negedge clk);
    checks++; if (b_next_en !== 1'b0) begin failures++; $display("[TB] FAIL full_empty_slot_next_en got=%b exp=0", b_next_en); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (b_valid !== 1'b1 || b_addr !== 20'(200 + i)) begin
        failures++; $display("[TB] FAIL drain_%0d got v=%b a=%0d exp v=1 a=%0d", i, b_valid, b_addr, 200 + i);
      end
      tick();
    end
    @(negedge clk);
    checks++; if (b_valid !== 1'b0 || b_ovf !== 1'b0) begin
      failures++; $display("[TB] FAIL drained_empty got v=%b o=%b exp v=0 o=0", b_valid, b_ovf); end
    tick();
  endtask

  task automatic test_small_frame;
    int writes;
    int dones;
    int done_cyc;
    writes   = 0;
    dones    = 0;
    done_cyc = -1;
    ready    = 1'b1;
    small_start = 1'b1;
    tick();
    small_start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc <= 8)
        drive_ray(1'b1, 1'b1, 4'd1, 2'd0, 4'd0, 20'(cyc - 1));
      else
        drive_ray(1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 20'd0);
      @(negedge clk);
      if (s_valid === 1'b1) begin
        checks++;
        if (s_addr !== 20'(writes) || s_data !== 16'h07E0) begin
          failures++; $display("[TB] FAIL frame_write_%0d got a=%0d d=%h exp a=%0d d=07e0", writes, s_addr, s_data, writes);
        end
        writes++;
      end
      if (s_done === 1'b1) begin
        dones++;
        done_cyc = cyc;
      end
      if (cyc == 8) begin
        checks++; if (s_stop !== 1'b0) begin failures++; $display("[TB] FAIL stop_before_last_issue got=%b exp=0", s_stop); end
      end
      if (cyc == 9) begin
        checks++; if (s_stop !== 1'b1) begin failures++; $display("[TB] FAIL stop_after_last_issue got=%b exp=1", s_stop); end
      end
      tick();
    end
    checks++; if (writes != 8) begin failures++; $display("[TB] FAIL frame_write_count got=%0d exp=8", writes); end
    checks++; if (dones != 1 || done_cyc != 10) begin
      failures++; $display("[TB] FAIL frame_done_pulse got count=%0d cyc=%0d exp count=1 cyc=10", dones, done_cyc); end
    checks++; if (s_ovf !== 1'b0) begin failures++; $display("[TB] FAIL frame_overflow got=%b exp=0", s_ovf); end
    small_start = 1'b1;
    tick();
    small_start = 1'b0;
    @(negedge clk);
    checks++; if (s_stop !== 1'b0) begin failures++; $display("[TB] FAIL back_to_idle_restart got stop=%b exp=0", s_stop); end
    tick();
  endtask

  task automatic test_frame;
    do_reset();
    test_small_frame();
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    small_start = 1'b1;
    tick();
    small_start = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_ray(1'b1, 1'b1, 4'd1, 2'd0, 4'd0, 20'(10 + i));
      tick();
    end
    drive_ray(1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 20'd0);
    @(negedge clk);
    checks++; if (s_stop !== 1'b1 || s_valid !== 1'b1 || s_addr !== 20'd10) begin
      failures++; $display("[TB] FAIL drain_full got stop=%b v=%b a=%0d exp 1 1 10", s_stop, s_valid, s_addr); end
    tick();
    ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    checks++; if (s_valid !== 1'b1 || s_addr !== 20'd15) begin
      failures++; $display("[TB] FAIL three_left got v=%b a=%0d exp v=1 a=15", s_valid, s_addr); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (s_next_en !== 1'b1 || s_stop !== 1'b1 || s_valid !== 1'b0 || s_addr !== 20'd0 ||
        s_data !== 16'd0 || s_done !== 1'b0 || s_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset got n=%b s=%b v=%b a=%0d d=%h fd=%b o=%b exp 1 1 0 0 0000 0 0",
               s_next_en, s_stop, s_valid, s_addr, s_data, s_done, s_ovf);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (s_valid !== 1'b0 || s_stop !== 1'b1) begin
      failures++; $display("[TB] FAIL post_reset_idle got v=%b stop=%b exp v=0 stop=1", s_valid, s_stop); end
    tick();
    test_small_frame();
  endtask

  initial begin
    test_reset();
    test_shade();
    test_backpressure();
    test_frame();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
